// File: rtl/vc_test_multi_rand_delay_sink_if.sv
// Purpose : val/rdy/msg bundle for a multi-channel stream into the test sink.
// Latency : none, wires only.
// Backpressure: rdy is driven by the sink; a beat moves when val && rdy on a channel.
// Ports   : val[p_nchan], rdy[p_nchan], msg[p_nchan*p_msg_nbits] (channel i at [i*p_msg_nbits +: p_msg_nbits]).
interface vc_test_multi_rand_delay_sink_if #(
    parameter int p_nchan     = 2,
    parameter int p_msg_nbits = 32
);
    logic [p_nchan-1:0]             val;
    logic [p_nchan-1:0]             rdy;
    logic [p_nchan*p_msg_nbits-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/vc_test_multi_rand_delay_sink.sv
// Purpose : multi-channel self-checking sink; per-channel expected-message memory,
//           ready-delay generator (none / fixed / LFSR-random) and in-order checker.
// Latency : a fire is checked in the cycle it happens; errors/done are visible the next cycle.
// Backpressure: after each fire a channel drops rdy for exactly d cycles (d from delay_mode).
// Ports   : clk, reset (sync, active-high), max_delay, delay_mode, load_val/load_chan/load_msg,
//           sif (val/rdy/msg slave), done, num_errors, err_valid, err_chan, err_idx.
// Option  : VC_TEST_SINK_ERR_HALT_EN - on the first error, freeze all rdy low and force done high.
module vc_test_multi_rand_delay_sink #(
    parameter int          p_nchan     = 2,
    parameter int          p_msg_nbits = 32,
    parameter int          p_num_msgs  = 1024,
    parameter logic [31:0] p_seed      = 32'hACE1_2D5B,
    localparam int         CW          = (p_nchan > 1) ? $clog2(p_nchan) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            max_delay,
    input  logic [1:0]             delay_mode,
    input  logic                   load_val,
    input  logic [CW-1:0]          load_chan,
    input  logic [p_msg_nbits-1:0] load_msg,
    vc_test_multi_rand_delay_sink_if.slave sif,
    output logic                   done,
    output logic [31:0]            num_errors,
    output logic                   err_valid,
    output logic [CW-1:0]          err_chan,
    output logic [31:0]            err_idx
);
    localparam int AW = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1;
    localparam int PW = $clog2(p_num_msgs + 1);   // pointers must be able to hold p_num_msgs

    typedef enum logic {ST_RDY, ST_WAIT} state_t;

    // Galois form of x^32 + x^22 + x^2 + x + 1 (right shift, mask on taps 32/22/2/1).
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [31:0] seed_of(input int ch);
        logic [31:0] s;
        s = p_seed ^ 32'(ch);
        seed_of = (s == 32'd0) ? 32'd1 : s;
    endfunction

    logic [p_msg_nbits-1:0] mem [p_nchan][p_num_msgs];

    state_t        state     [p_nchan];
    state_t        state_nxt [p_nchan];
    logic [31:0]   cnt       [p_nchan];
    logic [31:0]   cnt_nxt   [p_nchan];
    logic [31:0]   lfsr      [p_nchan];
    logic [31:0]   lfsr_nxt  [p_nchan];
    logic [PW-1:0] rp        [p_nchan];
    logic [PW-1:0] rp_nxt    [p_nchan];
    logic [PW-1:0] wp        [p_nchan];
    logic [PW-1:0] wp_nxt    [p_nchan];
    logic [31:0]   dly       [p_nchan];

    logic [p_nchan-1:0] rdy_int;
    logic [p_nchan-1:0] fire;
    logic [p_nchan-1:0] chan_err;
    logic [p_nchan-1:0] load_hit;
    logic [p_nchan-1:0] chan_done;

    logic [31:0]   num_err_q;
    logic [31:0]   num_err_nxt;
    logic [32:0]   err_sum;
    logic [31:0]   n_err;
    logic          err_valid_q;
    logic [CW-1:0] err_chan_q;
    logic [31:0]   err_idx_q;
    logic          first_hit;
    logic [CW-1:0] first_chan;
    logic [31:0]   first_idx;
    logic          halt;

`ifdef VC_TEST_SINK_ERR_HALT_EN
    assign halt = err_valid_q;
`else
    assign halt = 1'b0;
`endif

    // Delay candidate for the next fire; the +1 is done in 33 bits so max_delay=all-ones
    // yields modulus 2^32 (delay == raw lfsr) instead of wrapping to a divide by zero.
    always_comb begin
        for (int i = 0; i < p_nchan; i++) begin
            case (delay_mode)
                2'd0:    dly[i] = 32'd0;
                2'd1:    dly[i] = max_delay;
                default: dly[i] = 32'(({1'b0, lfsr[i]} % ({1'b0, max_delay} + 33'd1)));
            endcase
        end
    end

    always_comb begin
        n_err      = 32'd0;
        first_hit  = 1'b0;
        first_chan = '0;
        first_idx  = 32'd0;
        for (int i = 0; i < p_nchan; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            lfsr_nxt[i]  = lfsr[i];
            rp_nxt[i]    = rp[i];
            wp_nxt[i]    = wp[i];
            rdy_int[i]   = 1'b0;
            fire[i]      = 1'b0;
            chan_err[i]  = 1'b0;
            chan_done[i] = (rp[i] == wp[i]);
            load_hit[i]  = load_val && !reset && (load_chan == CW'(i)) &&
                           (wp[i] < PW'(p_num_msgs));
            if (load_hit[i])
                wp_nxt[i] = wp[i] + PW'(1);
            case (state[i])
                ST_RDY: begin
                    rdy_int[i] = !reset && !halt;
                    fire[i]    = rdy_int[i] && sif.val[i];
                    if (fire[i]) begin
                        // Compare against the pre-load wp: a same-cycle load is not yet visible.
                        if (rp[i] < wp[i]) begin
                            chan_err[i] = (sif.msg[i*p_msg_nbits +: p_msg_nbits] !=
                                           mem[i][rp[i][AW-1:0]]);
                            rp_nxt[i]   = rp[i] + PW'(1);
                        end else begin
                            chan_err[i] = 1'b1;   // overflow: nothing left to expect
                        end
                        lfsr_nxt[i] = lfsr_step(lfsr[i]);
                        if (dly[i] != 32'd0) begin
                            state_nxt[i] = ST_WAIT;
                            cnt_nxt[i]   = dly[i];
                        end
                    end
                end
                ST_WAIT: begin
                    cnt_nxt[i] = cnt[i] - 32'd1;
                    if (cnt[i] == 32'd1)
                        state_nxt[i] = ST_RDY;
                end
                default: state_nxt[i] = ST_RDY;
            endcase
            if (chan_err[i]) begin
                n_err = n_err + 32'd1;
                if (!first_hit) begin   // ascending scan: lowest channel wins
                    first_hit  = 1'b1;
                    first_chan = CW'(i);
                    first_idx  = 32'(rp[i]);
                end
            end
        end
        err_sum     = {1'b0, num_err_q} + {1'b0, n_err};
        num_err_nxt = err_sum[32] ? 32'hFFFF_FFFF : err_sum[31:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < p_nchan; i++) begin
                state[i] <= ST_RDY;
                cnt[i]   <= 32'd0;
                lfsr[i]  <= seed_of(i);
                rp[i]    <= '0;
                wp[i]    <= '0;
            end
            num_err_q   <= 32'd0;
            err_valid_q <= 1'b0;
            err_chan_q  <= '0;
            err_idx_q   <= 32'd0;
        end else begin
            for (int i = 0; i < p_nchan; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
                lfsr[i]  <= lfsr_nxt[i];
                rp[i]    <= rp_nxt[i];
                wp[i]    <= wp_nxt[i];
            end
            num_err_q <= num_err_nxt;
            if (!err_valid_q && first_hit) begin
                err_valid_q <= 1'b1;
                err_chan_q  <= first_chan;
                err_idx_q   <= first_idx;
            end
        end
    end

    // Expected-message storage survives reset on purpose.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_nchan; i++) begin
            if (load_hit[i])
                mem[i][wp[i][AW-1:0]] <= load_msg;
        end
    end

    assign sif.rdy    = rdy_int;
    assign done       = !reset && ((&chan_done) || halt);
    assign num_errors = reset ? 32'd0 : num_err_q;
    assign err_valid  = !reset && err_valid_q;
    assign err_chan   = reset ? '0 : err_chan_q;
    assign err_idx    = reset ? 32'd0 : err_idx_q;
endmodule

// File: tb/tb_vc_test_multi_rand_delay_sink.sv
// Purpose : directed bench for vc_test_multi_rand_delay_sink (2 channels, depth 4).
// Latency : inputs driven after negedge, outputs sampled 1 time unit later.
// Backpressure: source is modelled as always-valid while it has messages.
module tb_vc_test_multi_rand_delay_sink;
    localparam int NCH = 2;
    localparam int MW  = 32;
    localparam int NM  = 4;
`ifdef VC_TEST_SINK_ERR_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif
    localparam logic [31:0] SEED0 = 32'hACE1_2D5B;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] max_delay;
    logic [1:0]  delay_mode;
    logic        load_val;
    logic [0:0]  load_chan;
    logic [31:0] load_msg;
    logic        done;
    logic [31:0] num_errors;
    logic        err_valid;
    logic [0:0]  err_chan;
    logic [31:0] err_idx;

    int n_vec  = 0;
    int n_miss = 0;

    vc_test_multi_rand_delay_sink_if #(.p_nchan(NCH), .p_msg_nbits(MW)) sif ();

    vc_test_multi_rand_delay_sink #(
        .p_nchan(NCH), .p_msg_nbits(MW), .p_num_msgs(NM), .p_seed(SEED0)
    ) dut (
        .clk(clk), .reset(reset), .max_delay(max_delay), .delay_mode(delay_mode),
        .load_val(load_val), .load_chan(load_chan), .load_msg(load_msg),
        .sif(sif), .done(done), .num_errors(num_errors), .err_valid(err_valid),
        .err_chan(err_chan), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic        ld_ch;
        logic [31:0] ld_msg;
        logic [1:0]  v;
        logic [31:0] m0;
        logic [31:0] m1;
        logic [1:0]  e_rdy;
        logic        e_done;
        logic [31:0] e_nerr;
        logic        e_errv;
        logic        e_errch;
        logic [31:0] e_idx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic ld, logic ld_ch, logic [31:0] ld_msg,
                                logic [1:0] v, logic [31:0] m0, logic [31:0] m1,
                                logic [1:0] e_rdy, logic e_done, logic [31:0] e_nerr,
                                logic e_errv, logic e_errch, logic [31:0] e_idx);
        vec_t r;
        r.rst = rst; r.ld = ld; r.ld_ch = ld_ch; r.ld_msg = ld_msg;
        r.v = v; r.m0 = m0; r.m1 = m1;
        r.e_rdy = e_rdy; r.e_done = e_done; r.e_nerr = e_nerr;
        r.e_errv = e_errv; r.e_errch = e_errch; r.e_idx = e_idx;
        return r;
    endfunction

    function automatic vec_t rv();
        return mk(1, 0, 0, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        load_val = 1'b0; load_chan = 1'b0; load_msg = 32'd0;
        sif.val = 2'b00; sif.msg = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic load(input logic ch, input logic [31:0] m);
        load_val = 1'b1; load_chan = ch; load_msg = m;
        @(negedge clk);
        load_val = 1'b0;
    endtask

    // Mode 2 run on ch0 with 4 loaded messages 0x100+k; rdy0 is predicted by a local LFSR model.
    task automatic run_rand(input string tag, input logic [31:0] md, input int ncyc);
        logic [31:0] ml;
        logic [32:0] d;
        int          wait_c;
        int          k;
        logic        er;
        ml = SEED0; wait_c = 0; k = 0;
        for (int c = 0; c < ncyc; c++) begin
            er = (wait_c == 0);
            sif.val = {1'b0, (k < 4)};
            sif.msg = {32'd0, 32'h100 + 32'(k)};
            #1;
            chk($sformatf("%s_rdy0_c%0d", tag, c), 32'(sif.rdy[0]), 32'(er));
            if (er && k < 4) begin
                d = {1'b0, ml} % ({1'b0, md} + 33'd1);
                ml = step(ml);
                k++;
                wait_c = int'(d[31:0]);
            end else if (wait_c > 0) begin
                wait_c--;
            end
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_nerr"}, num_errors, 32'd0);
    endtask

    initial begin
        reset = 1'b1; delay_mode = 2'd0; max_delay = 32'd0;
        idle_inputs();

        // mode 0 streaming: ch0 three messages, ch1 one
        tbl.push_back(rv());
        tbl.push_back(mk(0, 1, 0, 'h11, 2'b00, 0, 0, 2'b11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h22, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 'h33, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'hA0, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b11, 'h11, 'hA0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b01, 'h22, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b01, 'h33, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b11, 1, 0, 0, 0, 0));
        // mismatch then overflow on ch1
        tbl.push_back(rv());
        tbl.push_back(mk(0, 1, 1, 'h5, 2'b00, 0, 0, 2'b11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 'h6, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 'h7, HALT ? 2'b00 : 2'b11, 1, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, HALT ? 2'b00 : 2'b11, 1, HALT ? 1 : 2, 1, 1, 0));
        // simultaneous first error on both channels
        tbl.push_back(rv());
        tbl.push_back(mk(0, 1, 0, 'h1, 2'b00, 0, 0, 2'b11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h2, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b11, 'h9, 'h9, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, HALT ? 2'b00 : 2'b11, 1, 2, 1, 0, 0));
        // load and fire in the same cycle: fire sees the pre-load pointer (overflow)
        tbl.push_back(rv());
        tbl.push_back(mk(0, 1, 0, 'h44, 2'b01, 'h44, 0, 2'b11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b01, 'h44, 0, HALT ? 2'b00 : 2'b11, HALT, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, HALT ? 2'b00 : 2'b11, 1, 1, 1, 0, 0));
        // memory full: fifth load dropped, fifth message is an overflow at index 4
        tbl.push_back(rv());
        tbl.push_back(mk(0, 1, 1, 'h10, 2'b00, 0, 0, 2'b11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h11, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h12, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h13, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 'h14, 2'b00, 0, 0, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 'h10, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 'h11, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 'h12, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 'h13, 2'b11, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, 2'b11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b10, 0, 'h14, 2'b11, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 2'b00, 0, 0, HALT ? 2'b00 : 2'b11, 1, 1, 1, 1, 4));

        foreach (tbl[i]) begin
            reset     = tbl[i].rst;
            load_val  = tbl[i].ld;
            load_chan = tbl[i].ld_ch;
            load_msg  = tbl[i].ld_msg;
            sif.val   = tbl[i].v;
            sif.msg   = {tbl[i].m1, tbl[i].m0};
            #1;
            chk($sformatf("v%0d_rdy", i), 32'(sif.rdy), 32'(tbl[i].e_rdy));
            chk($sformatf("v%0d_done", i), 32'(done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d_nerr", i), num_errors, tbl[i].e_nerr);
            chk($sformatf("v%0d_errv", i), 32'(err_valid), 32'(tbl[i].e_errv));
            chk($sformatf("v%0d_errch", i), 32'(err_chan), 32'(tbl[i].e_errch));
            chk($sformatf("v%0d_erridx", i), err_idx, tbl[i].e_idx);
            @(negedge clk);
        end

        // fixed delay 3: rdy 1,0,0,0 repeating, 4 fires in 13 cycles
        delay_mode = 2'd1; max_delay = 32'd3;
        do_reset();
        for (int j = 0; j < 4; j++) load(1'b0, 32'h200 + 32'(j));
        for (int c = 0; c < 13; c++) begin
            sif.val = 2'b01;
            sif.msg = {32'd0, 32'h200 + 32'(c / 4)};
            #1;
            chk($sformatf("fix_rdy0_c%0d", c), 32'(sif.rdy[0]), 32'((c % 4) == 0));
            @(negedge clk);
        end
        idle_inputs();
        #1;
        chk("fix_done", 32'(done), 32'd1);
        chk("fix_nerr", num_errors, 32'd0);

        // random delay, run twice from reset: both runs must follow the same model trace
        delay_mode = 2'd2; max_delay = 32'd5;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            for (int j = 0; j < 4; j++) load(1'b0, 32'h100 + 32'(j));
            run_rand($sformatf("rand%0d", r), 32'd5, 40);
            @(negedge clk);
        end

        // random with max_delay all-ones: delay is the raw seed, a very long wait
        delay_mode = 2'd3; max_delay = 32'hFFFF_FFFF;
        do_reset();
        load(1'b0, 32'h300);
        sif.val = 2'b01; sif.msg = {32'd0, 32'h300};
        #1;
        chk("huge_rdy_pre", 32'(sif.rdy), 32'h3);
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 20; c++) begin
            #1;
            chk($sformatf("huge_rdy_c%0d", c), 32'(sif.rdy), 32'h2);
            @(negedge clk);
        end
        chk("huge_nerr", num_errors, 32'd0);
        chk("huge_done", 32'(done), 32'd1);

        // reset in the middle of a fixed wait; a bogus fire during reset is ignored
        delay_mode = 2'd1; max_delay = 32'd10;
        do_reset();
        load(1'b0, 32'h400);
        sif.val = 2'b01; sif.msg = {32'd0, 32'h400};
        @(negedge clk);
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("midw_rdy_c%0d", c), 32'(sif.rdy), 32'h2);
            @(negedge clk);
        end
        reset = 1'b1; sif.val = 2'b11; sif.msg = {32'hDEAD, 32'hBEEF};
        #1;
        chk("midw_rst_rdy", 32'(sif.rdy), 32'h0);
        chk("midw_rst_done", 32'(done), 32'd0);
        chk("midw_rst_nerr", num_errors, 32'd0);
        @(negedge clk);
        reset = 1'b0; idle_inputs();
        #1;
        chk("midw_post_rdy", 32'(sif.rdy), 32'h3);
        chk("midw_post_done", 32'(done), 32'd1);
        chk("midw_post_nerr", num_errors, 32'd0);
        chk("midw_post_errv", 32'(err_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/vc_test_multi_rand_delay_sink.md
Name: vc_test_multi_rand_delay_sink

Overview:
- Multi-channel, self-checking test sink for unit-test harnesses.
- Each of p_nchan val/rdy input channels has its own expected-message memory, its own ready-delay generator (none / fixed / LFSR-random) and its own in-order checker.
- Aggregate error count, first-error capture and a global done flag.
- Replaces pairing one random-delay stage with one sink per stream.

Parameters:
p_nchan, 2, number of independent sink channels (>=1)
p_msg_nbits, 32, message width per channel
p_num_msgs, 1024, expected-message memory depth per channel
p_seed, 32'hACE1_2D5B, base LFSR seed; channel i seeded with p_seed ^ i (forced to 1 if result is 0)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
max_delay  input  32  delay bound for modes 1/2
delay_mode  input  2  0=no delay, 1=fixed max_delay, 2=random [0,max_delay], 3=treated as 2
load_val  input  1  append one expected message
load_chan  input  $clog2(p_nchan) (min 1)  target channel of load
load_msg  input  p_msg_nbits  expected message value
val  input  p_nchan  per-channel valid
rdy  output  p_nchan  per-channel ready
msg  input  p_nchan*p_msg_nbits  channel i occupies bits [i*p_msg_nbits +: p_msg_nbits]
done  output  1  all channels consumed all loaded messages
num_errors  output  32  total mismatches plus overflows, saturating
err_valid  output  1  first error captured
err_chan  output  $clog2(p_nchan) (min 1)  channel of first error
err_idx  output  32  message index of first error

Behaviour:
- Reset (synchronous):
  - Clears per-channel write pointer wp, read pointer rp, delay counter and error state; reloads LFSRs; every channel enters RDY.
  - Outputs during reset: rdy=0, done=0, num_errors=0, err_valid=0, err_chan=0, err_idx=0.
  - Memory contents are not cleared.
- Load:
  - load_val && !reset writes load_msg to mem[load_chan][wp] and increments wp.
  - If wp==p_num_msgs, the write is dropped.
  - Out-of-range load_chan is ignored.
  - A load and a handshake in the same cycle are both applied; the handshake compares against the pre-load wp.
- Per-channel FSM, states RDY and WAIT:
  - RDY: rdy=1. A fire (val&&rdy) consumes msg.
    - If rp<wp: compare msg to mem[rp]; mismatch -> error. Then rp++.
    - If rp>=wp: overflow error; rp unchanged.
  - On fire, delay d is computed: mode0 d=0; mode1 d=max_delay; mode2 d=lfsr % ({1'b0,max_delay}+1), evaluated in 33 bits.
    - d==0: stay in RDY.
    - Otherwise load cnt=d and go to WAIT.
    - LFSR advances once per fire only.
  - WAIT: rdy=0; cnt decrements each cycle; on cnt==1 go to RDY. Exactly d cycles of rdy low between handshakes.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, one per channel. Sequence is deterministic per channel regardless of other channels.
- Errors:
  - num_errors increments by the number of erroring channels in that cycle, saturating at 32'hFFFF_FFFF.
  - The first error cycle latches err_valid=1, err_chan and err_idx (rp before increment). On a simultaneous multi-channel first error, the lowest channel index wins.
  - Later errors never overwrite the capture.
- done=1 when rp==wp for all channels and not in reset. A channel with wp=0 counts as done. done drops again if a later load makes wp>rp.
- Changing delay_mode or max_delay mid-run affects only delays computed at subsequent fires; an in-progress WAIT completes unchanged.
- Reset asserted mid-WAIT or mid-stream aborts all state the next edge; a fire in the reset cycle is ignored.

Optional Feature:
- Macro: VC_TEST_SINK_ERR_HALT_EN.
- Defined: once err_valid=1, all rdy are forced 0 and done is forced 1 until reset, so the harness terminates on the first error. num_errors stops changing.
- Undefined: channels keep accepting after errors; done follows rp==wp only.

Test Plan:
- p_nchan=2, mode0: load ch0 {0x11,0x22,0x33}, ch1 {0xA0}, source always valid -> ch0 fires on 3 consecutive cycles, ch1 on 1; done=1 the cycle after the last fire; num_errors=0.
- Mode1, max_delay=3, ch0 with 4 messages -> rdy pattern 1,0,0,0,1,0,0,0,1,...; 4 fires over 13 cycles.
- Mode2, max_delay=0xFFFF_FFFF -> no width overflow; delay equals raw lfsr; rerun after reset reproduces an identical rdy trace.
- Error and overflow: ch1 expects 0x5, receives 0x6, then an extra message -> num_errors=2, err_valid=1, err_chan=1, err_idx=0. With VC_TEST_SINK_ERR_HALT_EN: rdy=0 after the first error, done=1, num_errors=1.
- Simultaneous: ch0 and ch1 both mismatch in the same cycle -> num_errors=2, err_chan=0.
- Reset mid-WAIT (mode1, max_delay=10): assert reset for 1 cycle -> rdy=0 during reset, rdy=1 the next cycle, done=1 (wp=rp=0), num_errors=0.
